dispatch_ctrl: RTL and testbench
================================

Name: dispatch_ctrl

Overview:
- Credit-based issue controller between the Decoder and the back end (ROB, RS, LSB).
- Buffers decoded instructions in a small in-order queue and allocates ROB tags itself.
- Dispatches the head only when the ROB and the target unit both have free slots.
- Back-pressures IFetch via dec_ready; recovers cleanly from a mispredict flush.

Parameters:
- ROB_SIZE, 16: ROB entries; tag 0 is reserved as "not renamed", so usable tags are 1..ROB_SIZE-1.
- RS_SIZE, 16: RS entries (initial RS credits).
- LSB_SIZE, 16: LSB entries (initial LSB credits).
- Q_DEPTH, 2: holding-queue depth.
- TAG_W, 4: ROB tag width, equal to clog2(ROB_SIZE).
- PAYLOAD_W, 96: opaque decoded payload width (op, imm, pc).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- rdy  in  1  global enable; when 0, all state holds
- flush  in  1  mispredict pulse from ROB
- dec_valid  in  1  Decoder offers an instruction
- dec_ready  out  1  controller accepts; 0 stalls IFetch
- dec_unit  in  2  target unit: 00 RS, 01 LSB, 10 ROB-only, 11 illegal (dropped)
- dec_has_rd  in  1  instruction writes rd
- dec_rd  in  5  destination register
- dec_payload  in  PAYLOAD_W  opaque payload
- rob_release  in  1  one ROB entry committed
- rs_release  in  1  one RS entry freed
- lsb_release  in  1  one LSB entry freed
- disp_valid  out  1  dispatch pulse, registered
- disp_to_rs  out  1  target RS
- disp_to_lsb  out  1  target LSB
- disp_tag  out  TAG_W  allocated ROB tag
- disp_rd  out  5  destination register
- disp_rd_we  out  1  regfile rename write (dec_has_rd and dec_rd != 0)
- disp_payload  out  PAYLOAD_W  payload

Behaviour:
- Reset (rst=0, asynchronous):
  - Queue empty; tail_tag=1.
  - Credits: rob=ROB_SIZE-1, rs=RS_SIZE, lsb=LSB_SIZE.
  - State RUN; all disp_* outputs 0; dec_ready=0 while in reset.
- States: RUN, FULL, RECOVER.
  - RUN -> FULL when the queue reaches Q_DEPTH.
  - FULL -> RUN when count drops below Q_DEPTH.
  - Any state -> RECOVER on flush.
  - RECOVER -> RUN after exactly 1 cycle.
- dec_ready = (state != RECOVER) && (count < Q_DEPTH); purely combinational from registers.
- Enqueue: on a clock edge with rdy && dec_valid && dec_ready. dec_unit=11 is accepted but never enqueued.
- Head is eligible when all hold: rdy, queue non-empty, rob_credit > 0, and the target unit credit > 0 (ROB-only needs only rob_credit).
- Dispatch on an edge where the head is eligible:
  - Pop the head and register disp_* with disp_tag = tail_tag.
  - disp_valid is high for exactly one cycle.
  - Decrement rob_credit and the target unit credit.
  - tail_tag increments, wrapping ROB_SIZE-1 -> 1 (never 0).
- Latency: instruction accepted at edge E0 with empty queue and credits available -> disp_valid high in the cycle after E1. Maximum throughput is 1 per cycle.
- Simultaneous enqueue and dispatch in one edge: count is unchanged; FIFO order preserved.
- Simultaneous release and dispatch on the same credit: net credit is unchanged.
- Credit overflow (release while at max) is an error: hold at max; simulation assertion fires.
- Flush has priority over enqueue, dispatch and release in the same edge:
  - Queue cleared, tail_tag=1, all credits restored to reset values.
  - disp_valid=0 next cycle; RECOVER blocks dec_ready for 1 cycle while IFetch redirects.
- rdy=0: every register holds, including credits and the FSM; disp_valid is forced 0. The release inputs are guaranteed 0 by their producers during this time.
- Reset mid-dispatch: outputs clear immediately (asynchronous); in-flight payload is discarded.

Optional Feature:
- Macro: DISPATCH_STATS_EN.
- Defined: adds outputs stat_dispatched[31:0] and stat_stall[31:0].
  - stat_dispatched counts disp_valid pulses.
  - stat_stall counts cycles with rdy && head valid && not eligible.
  - Both saturate at 2^32-1; reset to 0; NOT cleared by flush.
- Undefined: ports and counters absent; core behaviour identical.

Decomposition:
- Shared define package holds:
  - Unit encodings UNIT_RS, UNIT_LSB, UNIT_ROB, UNIT_ILL.
  - ROB_NOT_RENAMED = 0.
  - TAG_W, PAYLOAD_W.
  - FSM state encodings.
- Sub-module credit_counter (parameters MAX, W), instantiated three times:
  - Inputs: inc, dec, restore, hold.
  - Outputs: count, nonzero, plus the overflow assertion.

Test Plan:
1. Reset, then dec_valid with RS target each cycle for 20 cycles, no releases -> 15 dispatches (rob_credit limit) with tags 1..15; then dec_ready=0 after the queue fills.
2. LSB target with lsb_credit=0 and the RS queue behind it -> head blocks; no dispatch until lsb_release, then LSB op first, FIFO order kept.
3. Tag wrap: dispatch 15, release 15, dispatch 2 more -> tags 15 then 1 (never 0).
4. Flush with queue full and credits partly used -> next cycle: queue empty, dec_ready=0 for 1 cycle, credits full, next tag = 1.
5. rdy=0 for 5 cycles mid-stream -> no disp_valid, all state identical after rdy returns.
6. Simultaneous rs_release and RS dispatch at rs_credit=1 -> credit stays 1; a dec_rd=0 instruction yields disp_rd_we=0.

Source files
------------

// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch controller: unit encodings, tag and
// payload widths, and the controller FSM state encoding.
package dispatch_ctrl_pkg;

  localparam int TAG_W     = 4;
  localparam int PAYLOAD_W = 96;

  // Tag 0 marks a register as "not renamed"; it is never handed out.
  localparam logic [TAG_W-1:0] ROB_NOT_RENAMED = '0;

  typedef enum logic [1:0] {
    UNIT_RS  = 2'b00,
    UNIT_LSB = 2'b01,
    UNIT_ROB = 2'b10,
    UNIT_ILL = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_FULL    = 2'b01,
    ST_RECOVER = 2'b10
  } state_e;

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Saturating credit counter. Starts at MAX, decrements when a slot is
// consumed, increments when a slot is released, snaps back to MAX on restore
// and freezes while hold is high. A release while already at MAX is a
// producer bug: the count holds and the overflow assertion fires.
module dispatch_ctrl_credit_counter
  import dispatch_ctrl_pkg::*;
#(
  parameter int MAX = 16,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         restore,
  input  logic         hold,
  output logic [W-1:0] count,
  output logic         nonzero
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;

  // Credit update: restore wins, then hold, then net of inc/dec.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= MAX_V;
    end else if (restore) begin
      r_count <= MAX_V;
    end else if (!hold) begin
      if (inc && !dec) begin
        if (r_count != MAX_V) r_count <= r_count + 1'b1;
      end else if (dec && !inc) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign count   = r_count;
  assign nonzero = (r_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(inc && !dec && !restore && !hold && (r_count == MAX_V)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(dec && !inc && !restore && !hold && (r_count == '0)));

endmodule

// File: rtl/dispatch_ctrl.sv
// Credit-based issue controller between the decoder and the back end.
// Holds decoded instructions in a small in-order queue, allocates ROB tags,
// and dispatches the head when the ROB and its target unit both have credit.
// Optional build macro: DISPATCH_STATS_EN adds dispatch/stall counters.
//
// state   | meaning
// RUN     | queue has room, accepting from the decoder
// FULL    | queue holds Q_DEPTH entries, decoder stalled
// RECOVER | one cycle after a flush while fetch redirects
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_SIZE = 16,
  parameter int RS_SIZE  = 16,
  parameter int LSB_SIZE = 16,
  parameter int Q_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [1:0]           dec_unit,
  input  logic                 dec_has_rd,
  input  logic [4:0]           dec_rd,
  input  logic [PAYLOAD_W-1:0] dec_payload,
  input  logic                 rob_release,
  input  logic                 rs_release,
  input  logic                 lsb_release,
  output logic                 disp_valid,
  output logic                 disp_to_rs,
  output logic                 disp_to_lsb,
  output logic [TAG_W-1:0]     disp_tag,
  output logic [4:0]           disp_rd,
  output logic                 disp_rd_we,
  output logic [PAYLOAD_W-1:0] disp_payload
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]          stat_dispatched,
  output logic [31:0]          stat_stall
`endif
);

  localparam int QC_W   = $clog2(Q_DEPTH + 1);
  localparam int QP_W   = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int ROB_CW = $clog2(ROB_SIZE);
  localparam int RS_CW  = $clog2(RS_SIZE + 1);
  localparam int LSB_CW = $clog2(LSB_SIZE + 1);

  // Queue storage and bookkeeping
  unit_e                r_q_unit    [Q_DEPTH];
  logic                 r_q_has_rd  [Q_DEPTH];
  logic [4:0]           r_q_rd      [Q_DEPTH];
  logic [PAYLOAD_W-1:0] r_q_payload [Q_DEPTH];
  logic [QP_W-1:0]      r_rd_ptr, r_wr_ptr;
  logic [QC_W-1:0]      r_count, w_count_nxt;

  state_e               r_state, w_state_nxt;
  logic [TAG_W-1:0]     r_tail_tag;

  logic                 r_disp_valid, r_disp_to_rs, r_disp_to_lsb, r_disp_rd_we;
  logic [TAG_W-1:0]     r_disp_tag;
  logic [4:0]           r_disp_rd;
  logic [PAYLOAD_W-1:0] r_disp_payload;

  logic                 w_dec_ready, w_flush, w_accept, w_push, w_pop;
  logic                 w_head_valid, w_unit_ok, w_eligible;
  unit_e                w_head_unit;
  logic                 w_rob_nz, w_rs_nz, w_lsb_nz;
  logic [ROB_CW-1:0]    w_rob_cnt;
  logic [RS_CW-1:0]     w_rs_cnt;
  logic [LSB_CW-1:0]    w_lsb_cnt;

  function automatic logic [QP_W-1:0] ptr_inc(input logic [QP_W-1:0] p);
    return (p == QP_W'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A flush is only honoured while the core is enabled; rdy=0 freezes all.
  assign w_flush      = rdy && flush;
  assign w_accept     = rdy && dec_valid && w_dec_ready && !flush;
  assign w_push       = w_accept && (unit_e'(dec_unit) != UNIT_ILL);
  assign w_head_valid = (r_count != '0);
  assign w_head_unit  = r_q_unit[r_rd_ptr];

  // Target-unit credit check for the head entry; ROB-only needs no unit slot.
  always_comb begin
    w_unit_ok = 1'b0;
    case (w_head_unit)
      UNIT_RS:  w_unit_ok = w_rs_nz;
      UNIT_LSB: w_unit_ok = w_lsb_nz;
      UNIT_ROB: w_unit_ok = 1'b1;
      default:  w_unit_ok = 1'b0;
    endcase
  end

  assign w_eligible = rdy && w_head_valid && w_rob_nz && w_unit_ok;
  assign w_pop      = w_eligible && !flush;

  // Occupancy after this edge, ignoring flush (flush clears separately).
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (w_pop && !w_push) w_count_nxt = r_count - 1'b1;
  end

  // Queue write port; entries carry no reset, only pointers/count do.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_unit[r_wr_ptr]    <= unit_e'(dec_unit);
      r_q_has_rd[r_wr_ptr]  <= dec_has_rd;
      r_q_rd[r_wr_ptr]      <= dec_rd;
      r_q_payload[r_wr_ptr] <= dec_payload;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  // FSM next state and decoder handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_dec_ready = rst && (r_state != ST_RECOVER) && (r_count < QC_W'(Q_DEPTH));
    if (!rdy) begin
      w_state_nxt = r_state;
    end else if (flush) begin
      w_state_nxt = ST_RECOVER;
    end else begin
      case (r_state)
        ST_RUN:     if (w_count_nxt == QC_W'(Q_DEPTH)) w_state_nxt = ST_FULL;
        ST_FULL:    if (w_count_nxt <  QC_W'(Q_DEPTH)) w_state_nxt = ST_RUN;
        ST_RECOVER: w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Tag allocator: 1..ROB_SIZE-1, skipping the reserved tag 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tail_tag <= TAG_W'(1);
    end else if (w_flush) begin
      r_tail_tag <= TAG_W'(1);
    end else if (w_pop) begin
      r_tail_tag <= (r_tail_tag == TAG_W'(ROB_SIZE - 1)) ? TAG_W'(1) : r_tail_tag + 1'b1;
    end
  end

  // Registered dispatch outputs; valid is a single-cycle pulse per pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp_valid   <= 1'b0;
      r_disp_to_rs   <= 1'b0;
      r_disp_to_lsb  <= 1'b0;
      r_disp_tag     <= ROB_NOT_RENAMED;
      r_disp_rd      <= '0;
      r_disp_rd_we   <= 1'b0;
      r_disp_payload <= '0;
    end else begin
      r_disp_valid <= w_pop;
      if (w_pop) begin
        r_disp_to_rs   <= (w_head_unit == UNIT_RS);
        r_disp_to_lsb  <= (w_head_unit == UNIT_LSB);
        r_disp_tag     <= r_tail_tag;
        r_disp_rd      <= r_q_rd[r_rd_ptr];
        r_disp_rd_we   <= r_q_has_rd[r_rd_ptr] && (r_q_rd[r_rd_ptr] != 5'd0);
        r_disp_payload <= r_q_payload[r_rd_ptr];
      end
    end
  end

  dispatch_ctrl_credit_counter #(.MAX(ROB_SIZE - 1), .W(ROB_CW)) u_rob_credit (
    .clk     (clk),
    .rst     (rst),
    .inc     (rob_release),
    .dec     (w_pop),
    .restore (w_flush),
    .hold    (!rdy),
    .count   (w_rob_cnt),
    .nonzero (w_rob_nz)
  );

  dispatch_ctrl_credit_counter #(.MAX(RS_SIZE), .W(RS_CW)) u_rs_credit (
    .clk     (clk),
    .rst     (rst),
    .inc     (rs_release),
    .dec     (w_pop && (w_head_unit == UNIT_RS)),
    .restore (w_flush),
    .hold    (!rdy),
    .count   (w_rs_cnt),
    .nonzero (w_rs_nz)
  );

  dispatch_ctrl_credit_counter #(.MAX(LSB_SIZE), .W(LSB_CW)) u_lsb_credit (
    .clk     (clk),
    .rst     (rst),
    .inc     (lsb_release),
    .dec     (w_pop && (w_head_unit == UNIT_LSB)),
    .restore (w_flush),
    .hold    (!rdy),
    .count   (w_lsb_cnt),
    .nonzero (w_lsb_nz)
  );

  a_pop_has_credit: assert property (@(posedge clk) disable iff (!rst)
    w_pop |-> (w_rob_cnt != '0)
              && ((w_head_unit != UNIT_RS)  || (w_rs_cnt  != '0))
              && ((w_head_unit != UNIT_LSB) || (w_lsb_cnt != '0)));

`ifdef DISPATCH_STATS_EN
  logic [31:0] r_stat_dispatched, r_stat_stall;

  // Saturating activity counters; survive flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_dispatched <= '0;
      r_stat_stall      <= '0;
    end else if (rdy) begin
      if (w_pop && (r_stat_dispatched != '1))
        r_stat_dispatched <= r_stat_dispatched + 1'b1;
      if (w_head_valid && !w_eligible && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_dispatched = r_stat_dispatched;
  assign stat_stall      = r_stat_stall;
`endif

  assign dec_ready    = w_dec_ready;
  assign disp_valid   = r_disp_valid;
  assign disp_to_rs   = r_disp_to_rs;
  assign disp_to_lsb  = r_disp_to_lsb;
  assign disp_tag     = r_disp_tag;
  assign disp_rd      = r_disp_rd;
  assign disp_rd_we   = r_disp_rd_we;
  assign disp_payload = r_disp_payload;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: streaming loops for the long credit/tag
// runs and vector tables for the multi-cycle corner cases.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst, rdy, flush, dec_valid, dec_ready, dec_has_rd;
  logic [1:0]           dec_unit;
  logic [4:0]           dec_rd;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic                 rob_release, rs_release, lsb_release;
  logic                 disp_valid, disp_to_rs, disp_to_lsb, disp_rd_we;
  logic [TAG_W-1:0]     disp_tag;
  logic [4:0]           disp_rd;
  logic [PAYLOAD_W-1:0] disp_payload;
`ifdef DISPATCH_STATS_EN
  logic [31:0]          stat_dispatched, stat_stall;
`endif

  int checks     = 0;
  int failures   = 0;
  int n_exp_disp = 0;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .flush        (flush),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_unit     (dec_unit),
    .dec_has_rd   (dec_has_rd),
    .dec_rd       (dec_rd),
    .dec_payload  (dec_payload),
    .rob_release  (rob_release),
    .rs_release   (rs_release),
    .lsb_release  (lsb_release),
    .disp_valid   (disp_valid),
    .disp_to_rs   (disp_to_rs),
    .disp_to_lsb  (disp_to_lsb),
    .disp_tag     (disp_tag),
    .disp_rd      (disp_rd),
    .disp_rd_we   (disp_rd_we),
    .disp_payload (disp_payload)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_dispatched (stat_dispatched),
    .stat_stall      (stat_stall)
`endif
  );

  typedef struct {
    logic        dv;
    logic [1:0]  unit;
    logic        hr;
    logic [4:0]  rd;
    logic [31:0] pay;
    logic        rob_rel, rs_rel, lsb_rel, fl, rdy_i;
    logic        e_ready, e_valid;
    logic [3:0]  e_tag;
    logic [1:0]  e_unit;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_pay;
  } vec_t;

  vec_t t6[$];
  vec_t t2[$];
  vec_t t5[$];

  function automatic vec_t mk(input logic dv, input logic [1:0] u, input logic hr,
                              input logic [4:0] rd, input logic [31:0] pay,
                              input logic rob, input logic rs, input logic lsb,
                              input logic fl, input logic r,
                              input logic er, input logic ev, input logic [3:0] et,
                              input logic [1:0] eu, input logic ewe,
                              input logic [4:0] erd, input logic [31:0] epay);
    vec_t v;
    v.dv = dv; v.unit = u; v.hr = hr; v.rd = rd; v.pay = pay;
    v.rob_rel = rob; v.rs_rel = rs; v.lsb_rel = lsb; v.fl = fl; v.rdy_i = r;
    v.e_ready = er; v.e_valid = ev; v.e_tag = et; v.e_unit = eu;
    v.e_we = ewe; v.e_rd = erd; v.e_pay = epay;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic dv, input logic [1:0] u, input logic hr,
                       input logic [4:0] rd, input logic [31:0] pay,
                       input logic rob, input logic rs, input logic lsb,
                       input logic fl, input logic r);
    dec_valid   = dv;
    dec_unit    = u;
    dec_has_rd  = hr;
    dec_rd      = rd;
    dec_payload = {3{pay}};
    rob_release = rob;
    rs_release  = rs;
    lsb_release = lsb;
    flush       = fl;
    rdy         = r;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_out(input string lbl, input logic er, input logic ev,
                            input logic [3:0] et, input logic [1:0] eu,
                            input logic ewe, input logic [4:0] erd, input logic [31:0] epay);
    chk({lbl, ".ready"}, dec_ready, er);
    chk({lbl, ".valid"}, disp_valid, ev);
    if (ev) begin
      n_exp_disp++;
      chk({lbl, ".tag"},    disp_tag, et);
      chk({lbl, ".to_rs"},  disp_to_rs,  (eu == UNIT_RS));
      chk({lbl, ".to_lsb"}, disp_to_lsb, (eu == UNIT_LSB));
      chk({lbl, ".rd_we"},  disp_rd_we, ewe);
      chk({lbl, ".rd"},     disp_rd, erd);
      chk({lbl, ".payload"}, disp_payload, {3{epay}});
    end
  endtask

  task automatic run_table(input string grp, input vec_t tbl[$]);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].dv, tbl[i].unit, tbl[i].hr, tbl[i].rd, tbl[i].pay,
            tbl[i].rob_rel, tbl[i].rs_rel, tbl[i].lsb_rel, tbl[i].fl, tbl[i].rdy_i);
      step();
      expect_out($sformatf("%s[%0d]", grp, i), tbl[i].e_ready, tbl[i].e_valid,
                 tbl[i].e_tag, tbl[i].e_unit, tbl[i].e_we, tbl[i].e_rd, tbl[i].e_pay);
    end
  endtask

  initial begin
    // Release at rs_credit=1, flush with a full queue, illegal-unit drop.
    t6.push_back(mk(0, UNIT_RS,  0, 0, 0,      1,0,0,0,1, 0,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(0, UNIT_RS,  0, 0, 0,      1,1,0,0,1, 1,1,1,UNIT_RS,1,16,16));
    t6.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,1,2,UNIT_RS,0,0,17));
    t6.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(1, UNIT_RS,  0, 5, 'h100,  0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(1, UNIT_ROB, 1, 6, 'h101,  0,0,0,0,1, 0,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(1, UNIT_RS,  1, 6, 'h1ff,  1,0,0,1,1, 0,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(1, UNIT_ROB, 1, 6, 'h102,  0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(1, UNIT_ROB, 1, 7, 'h103,  0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,1,1,UNIT_ROB,1,7,'h103));
    t6.push_back(mk(1, UNIT_ILL, 1, 8, 'h104,  0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    t6.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    // LSB head blocked with an RS op behind it, then released.
    t2.push_back(mk(1, UNIT_RS,  1, 3, 'h300,  0,0,0,0,1, 0,0,0,UNIT_RS,0,0,0));
    t2.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 0,0,0,UNIT_RS,0,0,0));
    t2.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 0,0,0,UNIT_RS,0,0,0));
    t2.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,1,0,1, 0,0,0,UNIT_RS,0,0,0));
    t2.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,1,3,UNIT_LSB,1,17,'h211));
    t2.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,1,4,UNIT_RS,1,3,'h300));
    // rdy=0 for five cycles with a queued entry and the decoder still offering.
    t5.push_back(mk(1, UNIT_RS,  1, 9, 'h400,  0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));
    for (int i = 0; i < 5; i++)
      t5.push_back(mk(1, UNIT_RS, 1, 9, 'h4ff, 0,0,0,0,0, 1,0,0,UNIT_RS,0,0,0));
    t5.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,1,5,UNIT_RS,1,9,'h400));
    t5.push_back(mk(0, UNIT_RS,  0, 0, 0,      0,0,0,0,1, 1,0,0,UNIT_RS,0,0,0));

    rst = 1'b0;
    drive(0, UNIT_RS, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("reset.ready",   dec_ready, 1'b0);
    chk("reset.valid",   disp_valid, 1'b0);
    chk("reset.tag",     disp_tag, 4'd0);
    chk("reset.payload", disp_payload, '0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset.ready", dec_ready, 1'b1);
    @(negedge clk);

    // RS stream: the ROB credit limits the run to 15 dispatches, tags 1..15.
    for (int e = 1; e <= 20; e++) begin
      drive(1, UNIT_RS, 1, (e >= 17) ? 5'd0 : 5'(e), 32'(e), 0, 0, 0, 0, 1);
      step();
      expect_out($sformatf("rs_stream[%0d]", e), (e < 17), (e >= 2 && e <= 16),
                 4'(e - 1), UNIT_RS, 1'b1, 5'(e - 1), 32'(e - 1));
    end

    run_table("t6", t6);

    // LSB stream after flush (rob credit 14, next tag 2): exhausts LSB credit,
    // tags run 2..15 then wrap to 1, 2.
    for (int e = 1; e <= 17; e++) begin
      drive(1, UNIT_LSB, 1, 5'(e), 32'h200 + 32'(e), (e >= 2), 0, 0, 0, 1);
      step();
      expect_out($sformatf("lsb_stream[%0d]", e), 1'b1, (e >= 2),
                 4'(((e - 1) % 15) + 1), UNIT_LSB, 1'b1, 5'(e - 1), 32'h200 + 32'(e - 1));
    end

    run_table("t2", t2);
    run_table("t5", t5);

`ifdef DISPATCH_STATS_EN
    chk("stat_dispatched", stat_dispatched, 32'(n_exp_disp));
    chk("stat_stall_nonzero", (stat_stall != 32'd0), 1'b1);
`endif

    // Asynchronous reset while a dispatch pulse is on the outputs.
    drive(1, UNIT_RS, 1, 10, 'h500, 0, 0, 0, 0, 1);
    step();
    chk("mid.enq_valid", disp_valid, 1'b0);
    drive(0, UNIT_RS, 0, 0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    chk("mid.valid", disp_valid, 1'b1);
    chk("mid.tag",   disp_tag, 4'd6);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_reset.valid",   disp_valid, 1'b0);
    chk("mid_reset.tag",     disp_tag, 4'd0);
    chk("mid_reset.ready",   dec_ready, 1'b0);
    chk("mid_reset.payload", disp_payload, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
